// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   It works on operand magnitudes and fixes the signs on the final edge.
//   Divide-by-zero and signed overflow skip the iteration through a FAST
//   state and finish one edge after accept.
//
//   Optional build macro: MDU_DIV_EARLY_OUT_EN
//     When it is defined, a request whose dividend magnitude is below its
//     divisor magnitude also takes the FAST path. That path returns
//     quotient 0 and remainder = DATA1.
//
// Ports
//   CLK     : clock, rising edge
//   RESET   : synchronous active-high reset
//   START   : request valid, sampled only in IDLE
//   SELECT  : operation code (SEL_DIV / SEL_DIVU / SEL_REM / SEL_REMU)
//   DATA1   : dividend
//   DATA2   : divisor
//   BUSY    : request in flight (state != IDLE)
//   DONE    : one-cycle pulse, RESULT valid
//   RESULT  : quotient or remainder, held until the next DONE
// -----------------------------------------------------------------------------
module mdu_divider #(
  parameter int          WIDTH    = 32,
  parameter logic [4:0]  SEL_DIV  = 5'b01101,
  parameter logic [4:0]  SEL_DIVU = 5'b01110,
  parameter logic [4:0]  SEL_REM  = 5'b01111,
  parameter logic [4:0]  SEL_REMU = 5'b10000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [4:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FAST = 2'b10;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             fin_q,     fin_d;      // all quotient bits produced
  logic [WIDTH-1:0] quo_q,     quo_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] dvs_q,     dvs_d;      // divisor magnitude
  logic             is_rem_q,  is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             done_q,    done_d;

  // ---------------------------------------------------------------------------
  // Request decode (used only in IDLE)
  // ---------------------------------------------------------------------------
  logic             sel_valid, sel_signed, sel_rem;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, sgn_ovf, take_fast;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    sel_valid  = (SELECT == SEL_DIV) || (SELECT == SEL_DIVU) ||
                 (SELECT == SEL_REM) || (SELECT == SEL_REMU);
    sel_signed = (SELECT == SEL_DIV) || (SELECT == SEL_REM);
    sel_rem    = (SELECT == SEL_REM) || (SELECT == SEL_REMU);

    // The most negative value maps to itself here. That is still the correct
    // magnitude when it is read as an unsigned number.
    a_mag = (sel_signed && DATA1[WIDTH-1]) ? (~DATA1 + 1'b1) : DATA1;
    b_mag = (sel_signed && DATA2[WIDTH-1]) ? (~DATA2 + 1'b1) : DATA2;

    div_zero = (DATA2 == '0);
    sgn_ovf  = sel_signed && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (DATA2 == '1);

    // FAST results are final values. No sign correction is applied to them.
    if (div_zero) begin
      fast_res = sel_rem ? DATA1 : '1;
    end else if (sgn_ovf) begin
      fast_res = sel_rem ? '0 : DATA1;
    end else begin
      fast_res = sel_rem ? DATA1 : '0;       // early-out: |a| < |b|
    end

`ifdef MDU_DIV_EARLY_OUT_EN
    take_fast = div_zero || sgn_ovf || (a_mag < b_mag);
`else
    take_fast = div_zero || sgn_ovf;
`endif
  end

  // ---------------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into a (WIDTH+1)-bit
  // partial remainder, then subtract the divisor when the result fits.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   part_rem;
  logic             ge;
  logic [WIDTH-1:0] sub;

  always_comb begin
    part_rem = {rem_q, quo_q[WIDTH-1]};
    ge       = (part_rem >= {1'b0, dvs_q});
    // After a successful subtract the remainder is below the divisor, so it
    // fits in WIDTH bits.
    sub      = WIDTH'(part_rem - {1'b0, dvs_q});
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && sel_valid) begin
          is_rem_d  = sel_rem;
          neg_quo_d = sel_signed && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
          neg_rem_d = sel_signed && DATA1[WIDTH-1];
          cnt_d     = '0;
          fin_d     = 1'b0;
          rem_d     = '0;
          dvs_d     = b_mag;
          if (take_fast) begin
            quo_d   = fast_res;
            state_d = ST_FAST;
          end else begin
            quo_d   = a_mag;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (fin_q) begin
          // Dedicated edge for sign correction and result load.
          if (is_rem_q) begin
            result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          end else begin
            result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], ge};
          rem_d = ge ? sub : part_rem[WIDTH-1:0];
          if (cnt_q == CW'(WIDTH-1)) begin
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_FAST: begin
        result_d = quo_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// -----------------------------------------------------------------------------
// tb_mdu_divider
//   Directed vectors for mdu_divider. Each accepted request pushes its
//   expected RESULT, its accept edge and its expected latency into a queue.
//   A monitor pops that queue on every DONE and compares the popped entry.
// -----------------------------------------------------------------------------
module tb_mdu_divider;

  localparam logic [4:0] DIV  = 5'b01101;
  localparam logic [4:0] DIVU = 5'b01110;
  localparam logic [4:0] REM  = 5'b01111;
  localparam logic [4:0] REMU = 5'b10000;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  mdu_divider #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_issued = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h, want %h", nm, id, act, exp);
    end
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      n_done++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE at edge %0d, want none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", e.id, RESULT, e.res);
        chk("latency", e.id, 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_in_done", e.id, {31'b0, BUSY}, 32'd0);
      end
    end
  end

  // Called right after a negedge. It drives the request for one cycle.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input int id);
    exp_t e;
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    e.res = res; e.acc = cyc + 1; e.lat = lat; e.id = id;
    q.push_back(e);
    n_issued++;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout #%0d: got %0d pending, want 0", id, q.size());
      q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic wait_done(input int id);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!DONE && k < 200);
    if (!DONE) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout #%0d: got no DONE, want DONE", id);
    end
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; SELECT = 5'b0; DATA1 = '0; DATA2 = '0;
    repeat (2) @(negedge CLK);
    chk("reset_busy", 0, {31'b0, BUSY}, 32'd0);
    chk("reset_done", 0, {31'b0, DONE}, 32'd0);
    chk("reset_result", 0, RESULT, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Signed division with mixed signs
    issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1); wait_idle(1);
    issue(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 2); wait_idle(2);
    issue(DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 3); wait_idle(3);
    issue(REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 4);        wait_idle(4);

    // Back-to-back issue, with START pulses while BUSY that must be ignored
    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 5);
    repeat (3) begin
      SELECT = DIV; DATA1 = 32'd1; DATA2 = 32'd1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0; DATA1 = 32'hDEAD; DATA2 = 32'd0;
      @(negedge CLK);
    end
    wait_done(5);
    issue(REMU, 32'd100, 32'd7, 32'd2, 33, 6);
    wait_idle(6);

    // Divide by zero
    issue(DIV, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 7);  wait_idle(7);
    issue(REM, 32'd1234, 32'd0, 32'h000004D2, 1, 8);  wait_idle(8);
    issue(DIVU, 32'd55, 32'd0, 32'hFFFFFFFF, 1, 9);   wait_idle(9);
    issue(REMU, 32'd55, 32'd0, 32'd55, 1, 10);        wait_idle(10);

    // Signed overflow. The unsigned ops with the same operands use the normal path.
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 11);   wait_idle(11);
    issue(REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 12);   wait_idle(12);
    issue(DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 13); wait_idle(13);
    issue(REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 14); wait_idle(14);

    // An invalid SELECT is ignored
    SELECT = 5'b00000; DATA1 = 32'd9; DATA2 = 32'd3; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("invalid_sel_busy", 15, {31'b0, BUSY}, 32'd0);
    repeat (40) @(negedge CLK);

    // Reset in the middle of an operation discards it
    issue(DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 33, 16);
    repeat (9) @(negedge CLK);
    RESET = 1'b1;
    q.delete();
    n_issued--;
    @(negedge CLK);
    chk("midreset_busy", 16, {31'b0, BUSY}, 32'd0);
    chk("midreset_done", 16, {31'b0, DONE}, 32'd0);
    chk("midreset_result", 16, RESULT, 32'd0);
    RESET = 1'b0;
    repeat (40) @(negedge CLK);
    issue(DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 33, 17); wait_idle(17);

    // Dividend magnitude below divisor magnitude (latency depends on the build)
    issue(DIV, 32'd5, 32'd9, 32'd0, LAT_SMALL, 18);                   wait_idle(18);
    issue(REM, 32'd5, 32'd9, 32'd5, LAT_SMALL, 19);                   wait_idle(19);
    issue(REM, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFB, LAT_SMALL, 20);     wait_idle(20);
    issue(DIVU, 32'd0, 32'd9, 32'd0, LAT_SMALL, 21);                  wait_idle(21);

    chk("done_count", 99, 32'(n_done), 32'(n_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
